// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants.
// Register-bank sequencer states live here so the datapath control can observe them.
package mips_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  localparam reg_idx_t REG_ZERO    = 5'd0;
  localparam reg_idx_t REG_SP      = 5'd29;
  localparam reg_idx_t REG_RA      = 5'd31;
  localparam word_t    SP_INIT_VAL = 32'd227;

  typedef enum logic {
    RB_INIT,
    RB_RUN
  } rb_state_t;

endpackage

// File: rtl/reg_bank_init_seq.sv
// Reset sweep sequencer for reg_bank.
// Walks every register index once, clearing it or loading the stack pointer.
module reg_bank_init_seq
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SP_REG  = 29,
  parameter int unsigned SP_INIT = 227
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              sweep_en_o,
  output logic [ADDR_W-1:0] sweep_idx_o,
  output logic [DATA_W-1:0] sweep_data_o,
  output logic              run_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LastIdx = '1;

  rb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    unique case (state_q)
      RB_INIT: begin
        idx_d = idx_q + 1'b1;
        // Busy drops on the edge that writes the last register.
        if (idx_q == LastIdx) begin
          state_d = RB_RUN;
          busy_d  = 1'b0;
          idx_d   = '0;
        end
      end
      RB_RUN: begin
        state_d = RB_RUN;
      end
      default: begin
        state_d = RB_INIT;
        idx_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RB_INIT;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  assign sweep_en_o   = !reset_i && (state_q == RB_INIT);
  assign sweep_idx_o  = idx_q;
  assign sweep_data_o = (idx_q == ADDR_W'(SP_REG)) ? DATA_W'(SP_INIT) : '0;
  assign run_o        = (state_q == RB_RUN);
  assign busy_o       = busy_q;

endmodule

// File: rtl/reg_bank.sv
// 32-entry general-purpose register file: two registered read ports, one write port,
// write-first bypass, and a reset-time sweep that clears the array and seeds $sp.
module reg_bank
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SP_REG  = 29,
  parameter int unsigned SP_INIT = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              init_busy
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

  logic              sweep_en;
  logic [ADDR_W-1:0] sweep_idx;
  logic [DATA_W-1:0] sweep_data;
  logic              run;
  logic              wr_en;

  reg_bank_init_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SP_REG (SP_REG),
    .SP_INIT(SP_INIT)
  ) u_init_seq (
    .clk_i       (clk),
    .reset_i     (reset),
    .sweep_en_o  (sweep_en),
    .sweep_idx_o (sweep_idx),
    .sweep_data_o(sweep_data),
    .run_o       (run),
    .busy_o      (init_busy)
  );

  assign wr_en = run && !reset && reg_write && (write_reg != ADDR_W'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (sweep_en) begin
      regs_d[sweep_idx] = sweep_data;
    end else if (wr_en) begin
      regs_d[write_reg] = write_data;
    end
  end

  // Reads are forced to zero outside RUN; a same-cycle write wins over the stored value.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (run) begin
      if (wr_en && (write_reg == read_reg1)) begin
        rd1_d = write_data;
      end else if (read_reg1 != ADDR_W'(REG_ZERO)) begin
        rd1_d = regs_q[read_reg1];
      end
      if (wr_en && (write_reg == read_reg2)) begin
        rd2_d = write_data;
      end else if (read_reg2 != ADDR_W'(REG_ZERO)) begin
        rd2_d = regs_q[read_reg2];
      end
    end
  end

  // The array itself is not reset: the sweep rewrites every entry.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    if (reset) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign read_data1 = rd1_q;
  assign read_data2 = rd2_q;

endmodule
